// File: rtl/line_pkg.sv
// Shared sizing helpers for the multi-lane line deserializer.
// Everything here is elaboration-time arithmetic on the block parameters.
package line_pkg;

  // Number of bits in one complete image line.
  function automatic int line_bits(input int pixel_width, input int pixels);
    return pixel_width * pixels;
  endfunction

  function automatic int line_beats(input int w, input int lanes);
    return w / lanes;
  endfunction

  // A single-beat line still needs a one-bit counter to keep the logic uniform.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit lanes_divide(input int w, input int lanes);
    return (lanes > 0) && ((w % lanes) == 0);
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// LANES-wide, W-deep LSB-first shift register.
// next_o is the value the register takes on an enabled beat, so the top can capture a completing line without a bubble.
module lane_shift_reg #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [LANES-1:0] shift_i,
  output logic [W-1:0]     next_o
);

  generate
    if (LANES == W) begin : g_single_beat
      // The whole line arrives in one beat, so no history is kept.
      assign next_o = shift_i;
    end else begin : g_shift
      logic [W-1:0] sr_q;

      assign next_o = {shift_i, sr_q[W-1:LANES]};

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sr_q <= '0;
        end else if (en_i) begin
          sr_q <= next_o;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/line_deserializer.sv
// Multi-lane serial-to-parallel line capture with a double-buffered output,
// valid/ready handshake, sticky overrun flag and line resynchronisation.
module line_deserializer
  import line_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int PIXELS      = 32,
  parameter int LANES       = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [LANES-1:0]              shift_in,
  input  logic                          line_sync,
  output logic                          line_valid,
  input  logic                          line_ready,
  output logic [PIXELS*PIXEL_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]          line_count,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  localparam int W     = line_bits(PIXEL_WIDTH, PIXELS);
  localparam int BEATS = line_beats(W, LANES);
  localparam int BCW   = beat_cnt_width(BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  generate
    if (!lanes_divide(W, LANES)) begin : g_bad_lanes
      $error("line_deserializer: LANES must divide PIXELS*PIXEL_WIDTH");
    end
  endgenerate

  logic [W-1:0]         line_next;
  logic [BCW-1:0]       beat_q, beat_d, beat_base;
  logic                 valid_q, valid_d;
  logic [W-1:0]         data_q, data_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovr_q, ovr_d;
  logic                 complete, shadow_free, load, drop;

  lane_shift_reg #(
    .W     (W),
    .LANES (LANES)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (in_valid),
    .shift_i (shift_in),
    .next_o  (line_next)
  );

  // A sync beat restarts counting at zero, so the same beat can still be beat 0 of the new line.
  always_comb begin
    beat_base   = line_sync ? '0 : beat_q;
    complete    = in_valid && (beat_base == LAST_BEAT);
    shadow_free = !valid_q || line_ready;
    load        = complete && shadow_free;
    drop        = complete && !shadow_free;

    beat_d  = beat_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    ovr_d   = ovr_q;

    if (in_valid) begin
      beat_d = complete ? '0 : beat_base + 1'b1;
    end else if (line_sync) begin
      beat_d = '0;
    end

    if (load) begin
      valid_d = 1'b1;
      data_d  = line_next;
      count_d = count_q + 1'b1;
    end else if (valid_q && line_ready) begin
      valid_d = 1'b0;
    end

    // A dropped line wins over a simultaneous clear so no overrun goes unreported.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  assign line_valid = valid_q;
  assign data_out   = data_q;
  assign line_count = count_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_line_deserializer.sv
// Bench for line_deserializer: a 1-lane and a 4-lane instance of a 4-pixel line,
// with a bit-indexed line model driving expectations for the 1-lane instance.
module tb_line_deserializer;

  localparam int PW    = 8;
  localparam int PIX   = 4;
  localparam int W     = PW * PIX;
  localparam int CW    = 16;
  localparam int BEATS = W;

  logic          clk = 1'b0;
  logic          resetN;
  logic          inValid, shiftIn, lineSync, lineReady, clearOverrun;
  logic          lineValid, overrun;
  logic [W-1:0]  dataOut;
  logic [CW-1:0] lineCount;

  logic          inValid4, lineReady4;
  logic [3:0]    shiftIn4;
  logic          lineValid4, overrun4;
  logic [W-1:0]  dataOut4;
  logic [CW-1:0] lineCount4;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: line bits collected by index, plus the output buffer state.
  int            mBeat;
  logic [W-1:0]  mBuf;
  logic          mValid;
  logic [W-1:0]  mData;
  logic [CW-1:0] mCount;
  logic          mOverrun;

  always #5 clk = ~clk;

  line_deserializer #(
    .PIXEL_WIDTH(PW), .PIXELS(PIX), .LANES(1), .CNT_WIDTH(CW)
  ) dut1 (
    .clk(clk), .reset_n(resetN), .in_valid(inValid), .shift_in(shiftIn),
    .line_sync(lineSync), .line_valid(lineValid), .line_ready(lineReady),
    .data_out(dataOut), .line_count(lineCount), .overrun(overrun),
    .clear_overrun(clearOverrun)
  );

  line_deserializer #(
    .PIXEL_WIDTH(PW), .PIXELS(PIX), .LANES(4), .CNT_WIDTH(CW)
  ) dut4 (
    .clk(clk), .reset_n(resetN), .in_valid(inValid4), .shift_in(shiftIn4),
    .line_sync(1'b0), .line_valid(lineValid4), .line_ready(lineReady4),
    .data_out(dataOut4), .line_count(lineCount4), .overrun(overrun4),
    .clear_overrun(1'b0)
  );

  task automatic modelReset();
    mBeat    = 0;
    mBuf     = '0;
    mValid   = 1'b0;
    mData    = '0;
    mCount   = '0;
    mOverrun = 1'b0;
  endtask

  task automatic stepModel();
    bit done, dropped;
    done    = 0;
    dropped = 0;
    if (lineSync) mBeat = 0;
    if (inValid) begin
      mBuf[mBeat] = shiftIn;
      if (mBeat == BEATS - 1) begin
        done  = 1;
        mBeat = 0;
      end else begin
        mBeat++;
      end
    end
    if (done && (!mValid || lineReady)) begin
      mValid = 1'b1;
      mData  = mBuf;
      mCount = mCount + 16'd1;
    end else if (done) begin
      dropped = 1;
    end else if (mValid && lineReady) begin
      mValid = 1'b0;
    end
    if (dropped) mOverrun = 1'b1;
    else if (clearOverrun) mOverrun = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic applyReset();
    resetN       = 1'b0;
    inValid      = 1'b0;
    shiftIn      = 1'b0;
    lineSync     = 1'b0;
    lineReady    = 1'b0;
    clearOverrun = 1'b0;
    inValid4     = 1'b0;
    shiftIn4     = 4'h0;
    lineReady4   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic sendBeat(input logic b, input logic sync);
    inValid  = 1'b1;
    shiftIn  = b;
    lineSync = sync;
    cycle();
    inValid  = 1'b0;
    lineSync = 1'b0;
    shiftIn  = 1'($urandom);
  endtask

  task automatic test_reset();
    applyReset();
    compared += 4;
    if (lineValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", lineValid); end
    if (dataOut !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", dataOut); end
    if (lineCount !== '0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", lineCount); end
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single_line();
    logic [W-1:0] line;
    line = 32'h44332211;
    applyReset();
    for (int k = 0; k < BEATS - 1; k++) sendBeat(line[k], 1'b0);
    compared++;
    if (lineValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_valid: got %b expected 0", lineValid); end
    sendBeat(line[BEATS-1], 1'b0);
    compared += 3;
    if (lineValid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b expected 1", lineValid); end
    if (dataOut !== 32'h44332211) begin mismatched++; $display("[TB] FAIL single_data: got %h expected 44332211", dataOut); end
    if (lineCount !== 16'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", lineCount); end
    lineReady = 1'b1;
    cycle();
    lineReady = 1'b0;
    compared++;
    if (lineValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_consume: got %b expected 0", lineValid); end
  endtask

  task automatic test_multilane();
    logic [W-1:0] line;
    line = 32'h44332211;
    applyReset();
    for (int k = 0; k < 8; k++) begin
      inValid4 = 1'b1;
      shiftIn4 = line[4*k +: 4];
      if (k == 7) begin
        compared++;
        if (lineValid4 !== 1'b0) begin mismatched++; $display("[TB] FAIL lanes4_early_valid: got %b expected 0", lineValid4); end
      end
      cycle();
    end
    inValid4 = 1'b0;
    compared += 3;
    if (lineValid4 !== 1'b1) begin mismatched++; $display("[TB] FAIL lanes4_valid: got %b expected 1", lineValid4); end
    if (dataOut4 !== 32'h44332211) begin mismatched++; $display("[TB] FAIL lanes4_data: got %h expected 44332211", dataOut4); end
    if (lineCount4 !== 16'd1) begin mismatched++; $display("[TB] FAIL lanes4_count: got %0d expected 1", lineCount4); end
    lineReady4 = 1'b1;
    cycle();
    lineReady4 = 1'b0;
    compared++;
    if (lineValid4 !== 1'b0) begin mismatched++; $display("[TB] FAIL lanes4_consume: got %b expected 0", lineValid4); end
  endtask

  task automatic test_overrun();
    logic [W-1:0] l1, l2, l3;
    l1 = 32'hAABBCCDD;
    l2 = 32'h01020304;
    l3 = $urandom;
    applyReset();
    for (int k = 0; k < BEATS; k++) sendBeat(l1[k], 1'b0);
    for (int k = 0; k < BEATS; k++) sendBeat(l2[k], 1'b0);
    compared += 4;
    if (dataOut !== 32'hAABBCCDD) begin mismatched++; $display("[TB] FAIL ovr_data: got %h expected aabbccdd", dataOut); end
    if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
    if (lineCount !== 16'd1) begin mismatched++; $display("[TB] FAIL ovr_count: got %0d expected 1", lineCount); end
    if (lineValid !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_valid: got %b expected 1", lineValid); end
    clearOverrun = 1'b1;
    cycle();
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    // Clear held through another dropped line: the set must win.
    for (int k = 0; k < BEATS; k++) sendBeat(l3[k], 1'b0);
    clearOverrun = 1'b0;
    compared += 2;
    if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_priority: got %b expected 1", overrun); end
    if (dataOut !== 32'hAABBCCDD) begin mismatched++; $display("[TB] FAIL ovr_data_hold: got %h expected aabbccdd", dataOut); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] line;
    int loads;
    loads = 0;
    applyReset();
    lineReady = 1'b1;
    for (int n = 0; n < 3; n++) begin
      line = $urandom;
      for (int k = 0; k < BEATS; k++) begin
        sendBeat(line[k], 1'b0);
        if (lineValid === 1'b1) loads++;
      end
      compared += 2;
      if (lineValid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", n, lineValid); end
      if (dataOut !== line) begin mismatched++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", n, dataOut, line); end
    end
    lineReady = 1'b0;
    compared += 3;
    if (loads != 3) begin mismatched++; $display("[TB] FAIL b2b_loads: got %0d expected 3", loads); end
    if (lineCount !== 16'd3) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 3", lineCount); end
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_line_sync();
    logic [W-1:0] line;
    line = 32'h44332211;
    applyReset();
    for (int k = 0; k < 10; k++) sendBeat(1'($urandom), 1'b0);
    sendBeat(line[0], 1'b1);
    for (int k = 1; k < BEATS - 1; k++) sendBeat(line[k], 1'b0);
    compared++;
    if (lineValid !== 1'b0) begin mismatched++; $display("[TB] FAIL sync_early_valid: got %b expected 0", lineValid); end
    sendBeat(line[BEATS-1], 1'b0);
    compared += 3;
    if (lineValid !== 1'b1) begin mismatched++; $display("[TB] FAIL sync_valid: got %b expected 1", lineValid); end
    if (dataOut !== 32'h44332211) begin mismatched++; $display("[TB] FAIL sync_data: got %h expected 44332211", dataOut); end
    if (lineCount !== 16'd1) begin mismatched++; $display("[TB] FAIL sync_count: got %0d expected 1", lineCount); end
  endtask

  task automatic test_reset_midline();
    logic [W-1:0] l1, l3;
    l1 = $urandom;
    l3 = $urandom;
    applyReset();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < BEATS; k++) sendBeat(l1[k], 1'b0);
    for (int k = 0; k < 17; k++) sendBeat(1'($urandom), 1'b0);
    resetN = 1'b0;
    #2;
    compared += 4;
    if (lineValid !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_valid: got %b expected 0", lineValid); end
    if (dataOut !== '0) begin mismatched++; $display("[TB] FAIL arst_data: got %h expected 0", dataOut); end
    if (lineCount !== '0) begin mismatched++; $display("[TB] FAIL arst_count: got %0d expected 0", lineCount); end
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_overrun: got %b expected 0", overrun); end
    modelReset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int k = 0; k < BEATS; k++) sendBeat(l3[k], 1'b0);
    compared += 2;
    if (dataOut !== l3) begin mismatched++; $display("[TB] FAIL arst_after_data: got %h expected %h", dataOut, l3); end
    if (lineCount !== 16'd1) begin mismatched++; $display("[TB] FAIL arst_after_count: got %0d expected 1", lineCount); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    applyReset();
    for (int c = 0; c < 600; c++) begin
      inValid      = ($urandom_range(0, 3) != 0);
      shiftIn      = 1'($urandom);
      lineReady    = ($urandom_range(0, 2) == 0);
      lineSync     = ($urandom_range(0, 79) == 0);
      clearOverrun = ($urandom_range(0, 15) == 0);
      cycle();
      compared++;
      if (lineValid !== mValid || dataOut !== mData || lineCount !== mCount || overrun !== mOverrun) begin
        mismatched++;
        if (bad < 5) $display("[TB] FAIL rand_cycle%0d: got v=%b d=%h n=%0d o=%b expected v=%b d=%h n=%0d o=%b",
                              c, lineValid, dataOut, lineCount, overrun, mValid, mData, mCount, mOverrun);
        bad++;
      end
    end
    inValid      = 1'b0;
    lineSync     = 1'b0;
    lineReady    = 1'b0;
    clearOverrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_multilane();
    test_overrun();
    test_back_to_back();
    test_line_sync();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_deserializer.md
Name: line_deserializer

Overview:
Multi-lane serial-to-parallel line capture block, the parametrised successor of the single-bit shift/load line register.
- Accumulates one image line of PIXELS pixels × PIXEL_WIDTH bits from LANES serial inputs.
- Loads the completed line into a double-buffered output register and presents it with a valid/ready handshake.
- Detects overrun; supports line resynchronisation.
- Sits between the sensor readout serialiser and the line consumer (packer / output writer).

Parameters:
PIXEL_WIDTH, 8, bits per pixel
PIXELS, 32, pixels per line
LANES, 1, serial bits accepted per beat; must divide PIXELS*PIXEL_WIDTH (elaboration error otherwise)
CNT_WIDTH, 16, width of the line counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  shift_in carries a valid beat this cycle
shift_in  in  LANES  serial data; lane l carries the lower-index bit of the beat
line_sync  in  1  start-of-line pulse; discards any partial line
line_valid  out  1  data_out holds an unconsumed line
line_ready  in  1  consumer accepts data_out when line_valid is high
data_out  out  PIXELS*PIXEL_WIDTH  completed line; pixel p at data_out[p*PIXEL_WIDTH +: PIXEL_WIDTH]
line_count  out  CNT_WIDTH  lines loaded into data_out since reset; wraps modulo 2^CNT_WIDTH
overrun  out  1  sticky: a completed line was dropped
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- W = PIXELS*PIXEL_WIDTH; BEATS = W/LANES; beat counter is clog2(BEATS) bits, range 0..BEATS-1.
- Reset (asynchronous, any time including mid-line):
  - shift register, data_out, beat counter and line_count go to 0.
  - line_valid and overrun go to 0.
  - Any partial line is lost.
- Bit ordering (LSB first): beat k, lane l delivers line bit k*LANES+l.
  - Shift: sr <= {shift_in, sr[W-1:LANES]} on each accepted beat.
- Accepted beat: in_valid=1. The beat counter increments; at BEATS-1 it wraps to 0 (completing beat).
- Completing beat, shadow free (line_valid=0, or line_valid=1 with line_ready=1 in the same cycle):
  - data_out <= {shift_in, sr[W-1:LANES]}.
  - line_valid=1 from the next cycle; line_count += 1.
  - No bubble, so a full-rate stream with line_ready tied high loses nothing.
- Completing beat, shadow busy (line_valid=1, line_ready=0):
  - New line is dropped; data_out, line_count and line_valid unchanged.
  - overrun <= 1.
  - The shift register continues with the next line.
- Handshake:
  - Transfer occurs when line_valid && line_ready.
  - line_valid falls the next cycle unless a completing beat reloads it in that same cycle.
  - data_out is stable while line_valid=1 and line_ready=0.
- line_sync=1:
  - Beat counter forced to 0; the partial line is discarded.
  - If in_valid is also high, that beat is taken as beat 0 of the new line (counter becomes 1; with BEATS=1 the line completes).
  - line_sync does not affect line_valid, data_out or overrun.
- overrun:
  - Set has priority over clear_overrun in the same cycle.
  - Otherwise clear_overrun=1 clears it next cycle.
- in_valid=0: no state change apart from the handshake and line_sync.
- Latency: last beat at cycle N gives line_valid/data_out at N+1.
- Fully synchronous to clk; no combinational path from inputs to outputs.

Decomposition:
- Package line_pkg: derived W, BEATS and beat-counter width functions; the LANES-divisibility check helper.
- One natural sub-module, lane_shift_reg: LANES-wide, W-deep shift register with in_valid enable and async reset.
- The top holds the beat counter, shadow/handshake, overrun and line counter.

Test Plan:
- PW=8, PIXELS=4, LANES=1: 32 beats carrying bits of 0x44332211 LSB first -> line_valid the cycle after beat 32; data_out=0x44332211; line_count=1.
- LANES=4, same line, 8 beats -> identical data_out; line_valid after beat 8; then line_ready=1 for one cycle -> line_valid=0 next cycle.
- Two back-to-back lines (0xAABBCCDD, then 0x01020304) with line_ready held 0 -> data_out stays 0xAABBCCDD; overrun=1; line_count=1. Then clear_overrun -> overrun=0.
- Continuous stream, line_ready tied 1, three lines -> three consecutive loads, no overrun, line_count=3, no gap cycles in line_valid.
- 10 beats of garbage, then line_sync coincident with the first beat of 0x44332211 -> data_out=0x44332211 after 32 beats counted from the sync beat.
- reset_n pulsed low mid-line (beat 17) and while line_valid=1 -> all outputs 0 immediately; the next full 32-beat line captured correctly; line_count=1.
